unary_stream_encoder: RTL and testbench
=======================================

UNARY_STREAM_ENCODER -- requirements
Module: unary_stream_encoder

Interface
REQ-001 Parameter BIN_BITS SHALL default to 4 and set the binary operand width.
REQ-002 Parameter U_BITS SHALL default to 1 << BIN_BITS and set the unary frame length in cycles; it is derived and SHALL NOT be overridden.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 Port bin_a, input, BIN_BITS: operand A, unsigned binary.
REQ-006 Port bin_b, input, BIN_BITS: operand B, unsigned binary.
REQ-007 Port bin_valid, input, 1: bin_a and bin_b are valid this cycle.
REQ-008 Port bin_ready, output, 1: the encoder accepts an operand pair this cycle.
REQ-009 Port u_a, output, 1: unary stream for A.
REQ-010 Port u_b, output, 1: unary stream for B.
REQ-011 Port u_valid, output, 1: u_a and u_b carry a frame bit this cycle.
REQ-012 Port busy, output, 1: a frame is being emitted (state SEND).

Function
REQ-013 An operand pair SHALL be accepted on a rising edge where bin_valid and bin_ready are both 1; the pair is latched into internal registers, so later input changes do not affect the frame.
REQ-014 States: IDLE (no frame, no pending pair), SEND (emitting a frame), GAP (one idle cycle after a frame).
REQ-015 Transitions: IDLE->SEND on accept; SEND->SEND while frame counter k < U_BITS-1; SEND->GAP at k = U_BITS-1; GAP->SEND on accept; GAP->IDLE otherwise.
REQ-016 bin_ready SHALL be 1 in IDLE and GAP and 0 in SEND, except as modified by REQ-024.
REQ-017 All outputs except bin_ready SHALL be registered; the first frame bit SHALL appear the cycle after the accepting edge (latency 1).
REQ-018 In SEND, u_valid SHALL be 1 for exactly U_BITS consecutive cycles, k = 0..U_BITS-1.
REQ-019 In frame cycle k, u_a SHALL equal (k < A) and u_b SHALL equal (k < B): thermometer code, ones first, then zeros.
REQ-020 Frame bit k = U_BITS-1 is always 0, because the maximum operand is U_BITS-1; a frame for value 0 is all zeros with u_valid still high for U_BITS cycles.
REQ-021 In IDLE and GAP, u_a, u_b and u_valid SHALL be 0.
REQ-022 The frame counter SHALL be log2(U_BITS)+1 bits wide and reset to 0 at every frame start; it SHALL NOT wrap inside a frame.
REQ-023 bin_valid held high continuously SHALL yield frames separated by exactly one u_valid=0 cycle, one accepted pair per frame, with none dropped or duplicated.

Reset
REQ-024 When reset_n = 0 at a rising edge, the block SHALL enter IDLE with the counter at 0, operand registers at 0, and u_a = u_b = u_valid = busy = 0 after that edge; bin_ready SHALL be 0 while reset_n = 0.
REQ-025 Reset during SEND SHALL abort the frame immediately; the partial frame is not resumed, and no accept occurs on the reset edge.

Configuration
REQ-026 Macro UNARY_ENC_BACK2BACK_EN: when defined, bin_ready SHALL also be 1 in SEND at k = U_BITS-1, and an accept there SHALL go SEND->SEND with k = 0, giving back-to-back frames with no idle cycle.
REQ-027 When UNARY_ENC_BACK2BACK_EN is undefined, behaviour is exactly REQ-014 to REQ-023, and consecutive frames are always separated by at least one GAP cycle.

Verification
REQ-028 Reset, then send A=3, B=2 -> u_valid high for 16 cycles starting the cycle after accept; u_a = 1110000000000000, u_b = 1100000000000000 in time order.
REQ-029 Send A=15, B=0, then A=0, B=5 -> 15 ones on u_a and 0 on u_b, then 0 on u_a and 5 on u_b; 16 u_valid cycles each.
REQ-030 Hold bin_valid=1 with pairs (10,9),(4,15),(15,15) -> three frames with ones-counts matching, one idle cycle between frames (macro undefined) or zero idle cycles (macro defined).
REQ-031 Assert reset_n=0 during cycle k=7 of an A=15 frame -> u_valid=0 the next cycle, state IDLE, bin_ready=1 after reset is released, and the next pair (3,2) encodes correctly.
REQ-032 Drive bin_valid=1 in SEND mid-frame with bin_a=7 -> bin_ready=0, the pair is not accepted, and the current frame is unchanged.
REQ-033 Chain with unary_shift_multiplier: operands (3,2),(4,15),(10,9) -> the counted ones on the multiplier output equal 6, 60, 90.

Source files
------------

// File: rtl/unary_stream_encoder.sv
// Purpose : turn a pair of unsigned binary operands into two thermometer-coded unary
//           bit streams (ones first), U_BITS frame cycles per pair.
// Latency : first frame bit appears the cycle after the accepting edge; all outputs
//           except bin_ready are registered.
// Backpressure: bin_ready is low while a frame is being emitted and while reset_n is low.
//           With UNARY_ENC_BACK2BACK_EN defined, it is also high on the last frame cycle,
//           so frames can run back to back.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - synchronous active-low reset
//   bin_a/b    - operands, BIN_BITS wide, unsigned
//   bin_valid  - operand pair valid
//   bin_ready  - operand pair accepted when bin_valid & bin_ready at a rising edge
//   u_a/u_b    - unary streams, u_valid qualifies them
//   busy       - a frame is being emitted
// Optional feature macro: UNARY_ENC_BACK2BACK_EN
module unary_stream_encoder #(
  parameter int BIN_BITS = 4,
  // Derived frame length; leave at its default.
  parameter int U_BITS   = 1 << BIN_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BIN_BITS-1:0] bin_a,
  input  logic [BIN_BITS-1:0] bin_b,
  input  logic                bin_valid,
  output logic                bin_ready,
  output logic                u_a,
  output logic                u_b,
  output logic                u_valid,
  output logic                busy
);

  // Counter is log2(U_BITS)+1 bits, so it can never wrap inside a frame.
  localparam int K_BITS = BIN_BITS + 1;
  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(U_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [K_BITS-1:0]   r_k;
  logic [K_BITS-1:0]   w_k_nxt;
  logic [BIN_BITS-1:0] r_a;
  logic [BIN_BITS-1:0] r_b;
  logic [BIN_BITS-1:0] w_a_nxt;
  logic [BIN_BITS-1:0] w_b_nxt;
  logic                w_last;
  logic                w_ready;
  logic                w_accept;
  logic                w_u_a_nxt;
  logic                w_u_b_nxt;
  logic                w_u_valid_nxt;
  logic                w_busy_nxt;

  assign w_last = (r_state == S_SEND) && (r_k == K_LAST);

`ifdef UNARY_ENC_BACK2BACK_EN
  // Last frame cycle may take the next pair so the following frame starts without a gap.
  assign w_ready = reset_n && ((r_state != S_SEND) || w_last);
`else
  assign w_ready = reset_n && (r_state != S_SEND);
`endif

  assign bin_ready = w_ready;
  assign w_accept  = bin_valid && w_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_accept)    w_state_nxt = S_SEND;
        else if (w_last) w_state_nxt = S_GAP;
        else             w_state_nxt = S_SEND;
      end
      S_GAP:  w_state_nxt = w_accept ? S_SEND : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_k_nxt = r_k;
    if (w_accept) begin
      w_k_nxt = '0;
    end else if ((r_state == S_SEND) && !w_last) begin
      w_k_nxt = r_k + K_BITS'(1);
    end
    w_a_nxt       = w_accept ? bin_a : r_a;
    w_b_nxt       = w_accept ? bin_b : r_b;
    w_busy_nxt    = (w_state_nxt == S_SEND);
    w_u_valid_nxt = w_busy_nxt;
    // Thermometer code: bit k is one while k < operand.
    w_u_a_nxt     = w_busy_nxt && (w_k_nxt < K_BITS'(w_a_nxt));
    w_u_b_nxt     = w_busy_nxt && (w_k_nxt < K_BITS'(w_b_nxt));
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      u_a     <= 1'b0;
      u_b     <= 1'b0;
      u_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_k     <= w_k_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      u_a     <= w_u_a_nxt;
      u_b     <= w_u_b_nxt;
      u_valid <= w_u_valid_nxt;
      busy    <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_unary_stream_encoder.sv
// Purpose : randomized and directed stimulus for unary_stream_encoder, checked against a
//           frame-level reference model through a scoreboard queue.
// Latency : model expects the first frame bit the cycle after the accepting edge.
// Backpressure: model predicts bin_ready from the number of frame cycles still to send.
module tb_unary_stream_encoder;

  localparam int BB = 4;
  localparam int U  = 1 << BB;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [BB-1:0] bin_a;
  logic [BB-1:0] bin_b;
  logic          bin_valid;
  logic          bin_ready;
  logic          u_a;
  logic          u_b;
  logic          u_valid;
  logic          busy;

  always #5 clk = ~clk;

  unary_stream_encoder #(.BIN_BITS(BB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bin_a     (bin_a),
    .bin_b     (bin_b),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .u_a       (u_a),
    .u_b       (u_b),
    .u_valid   (u_valid),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] bit_q[$];   // expected {u_a,u_b} per frame cycle
  int         frm_a[$];   // expected operand per frame
  int         frm_b[$];
  int         busy_cnt = 0;  // frame cycles still to be emitted
  int         n_acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d, t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
`ifdef UNARY_ENC_BACK2BACK_EN
    return (reset_n === 1'b1) && (busy_cnt <= 1);
`else
    return (reset_n === 1'b1) && (busy_cnt == 0);
`endif
  endfunction

  // Reference model: a frame is U cycles; bit k of operand v is (k < v).
  always @(posedge clk) begin
    if (reset_n !== 1'b1) begin
      busy_cnt = 0;
      bit_q.delete();
      frm_a.delete();
      frm_b.delete();
    end else if (bin_valid && model_ready()) begin
      for (int k = 0; k < U; k++) bit_q.push_back({k < int'(bin_a), k < int'(bin_b)});
      frm_a.push_back(int'(bin_a));
      frm_b.push_back(int'(bin_b));
      busy_cnt = U;
      n_acc++;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  int idx = 0;
  int ca  = 0;
  int cb  = 0;
  always @(negedge clk) begin
    logic [1:0] e;
    chk("u_valid",   int'(u_valid),   int'(busy_cnt > 0));
    chk("busy",      int'(busy),      int'(busy_cnt > 0));
    chk("bin_ready", int'(bin_ready), int'(model_ready()));
    if (u_valid === 1'b1) begin
      if (bit_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_bit: u_valid high, expected no frame bit, t=%0t", $time);
      end else begin
        e = bit_q.pop_front();
        chk("u_a", int'(u_a), int'(e[1]));
        chk("u_b", int'(u_b), int'(e[0]));
        ca += int'(u_a);
        cb += int'(u_b);
        idx++;
        if (idx == U) begin
          if (frm_a.size() > 0) begin
            chk("ones_a",  ca,      frm_a[0]);
            chk("ones_b",  cb,      frm_b[0]);
            chk("product", ca * cb, frm_a[0] * frm_b[0]);
            void'(frm_a.pop_front());
            void'(frm_b.pop_front());
          end
          idx = 0;
          ca  = 0;
          cb  = 0;
        end
      end
    end else begin
      idx = 0;
      ca  = 0;
      cb  = 0;
    end
  end

  // Present a pair and hold it until the model sees it accepted (bounded wait).
  task automatic send(input int a, input int b);
    int start;
    start     = n_acc;
    bin_a     = BB'(a);
    bin_b     = BB'(b);
    bin_valid = 1'b1;
    for (int i = 0; i < 64 && n_acc == start; i++) begin
      @(posedge clk);
      #1;
    end
    if (n_acc == start) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pair (%0d,%0d) not accepted, expected accept within 64 cycles", a, b);
    end
  endtask

  task automatic idle(input int n);
    bin_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int a;
    int b;
    reset_n   = 1'b0;
    bin_valid = 1'b0;
    bin_a     = '0;
    bin_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    send(3, 2);
    idle(20);
    send(15, 0);
    send(0, 5);
    idle(20);

    // Held valid: frames separated by the model-predicted gap (or none).
    send(10, 9);
    send(4, 15);
    send(15, 15);
    idle(20);

    // Offer a pair mid-frame; it must be refused and the frame left intact.
    send(6, 1);
    bin_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bin_a     = 4'd7;
    bin_b     = 4'd7;
    bin_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    idle(15);

    // Reset during frame cycle k=7; no accept on the reset edge.
    send(15, 3);
    bin_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset_n   = 1'b0;
    bin_a     = 4'd9;
    bin_b     = 4'd9;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    bin_valid = 1'b0;
    @(posedge clk);
    #1;
    send(3, 2);
    idle(20);

    // Random pairs, sometimes streamed, sometimes with idle spacing.
    repeat (40) begin
      a = int'($urandom_range(0, U - 1));
      b = int'($urandom_range(0, U - 1));
      send(a, b);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 20)));
    end
    idle(40);
    chk("queue_drained", bit_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
